// File: rtl/rec_pkg.sv
// Shared constants for the recursive evaluation engine: FSM encodings,
// base-case threshold and recursion-mode selectors.
package rec_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] EVAL = 2'd2;
    localparam logic [1:0] FIN  = 2'd3;

    localparam int unsigned BASE_MAX = 1;

    localparam logic TWOTHREE_FIB = 1'b1;
    localparam logic TWOTHREE_PAD = 1'b0;

endpackage

// File: rtl/rec_stack.sv
// DEPTH x N_W LIFO of pending indices; supports push, pop and
// replace-top-and-push in a single cycle, plus a clear for a fresh run.
module rec_stack
    import rec_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned N_W   = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic             repl,
    input  logic [N_W-1:0]   wr_top,
    input  logic [N_W-1:0]   wr_new,
    output logic [N_W-1:0]   top,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [N_W-1:0]   mem_q [DEPTH];
    logic [N_W-1:0]   mem_d [DEPTH];
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] base;
    logic [AW-1:0]    top_idx, nxt_idx;

    // clr lets a new run start from an empty stack even after an aborted one
    assign base    = clr ? '0 : count_q;
    assign top_idx = AW'(base - CNT_W'(1));
    assign nxt_idx = AW'(base);

    // Callers must not push/repl when full; nxt_idx would alias entry 0
    always_comb begin
        mem_d   = mem_q;
        count_d = base;
        if (repl) begin
            mem_d[top_idx] = wr_top;
            mem_d[nxt_idx] = wr_new;
            count_d        = base + CNT_W'(1);
        end else if (push) begin
            mem_d[nxt_idx] = wr_new;
            count_d        = base + CNT_W'(1);
        end else if (pop) begin
            count_d        = base - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign top   = mem_q[AW'(count_q - CNT_W'(1))];
    assign count = count_q;
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/rec_eval_engine.sv
// Sequential evaluator of the two-term recursion f(n): walks the call tree
// depth-first using rec_stack, one node per clock, accumulating leaf counts.
module rec_eval_engine
    import rec_pkg::*;
#(
    parameter int unsigned N_W   = 4,
    parameter int unsigned R_W   = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           twothree,
    input  logic [N_W-1:0] n,
    output logic           busy,
    output logic           done,
    output logic [R_W-1:0] result,
    output logic           overflow,
    output logic           saturated
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [1:0]       state_q, state_d;
    logic [N_W-1:0]   n_q, n_d;
    logic             mode_q, mode_d;
    logic [R_W-1:0]   acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic             sat_q, sat_d;

    logic             st_clr, st_push, st_pop, st_repl;
    logic [N_W-1:0]   st_top, st_new, far_term, near_term;
    logic [CNT_W-1:0] st_count;
    logic             st_full, st_empty;
    logic             leaf;

    rec_stack #(
        .DEPTH (DEPTH),
        .N_W   (N_W)
    ) u_stack (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (st_clr),
        .push   (st_push),
        .pop    (st_pop),
        .repl   (st_repl),
        .wr_top (far_term),
        .wr_new (st_new),
        .top    (st_top),
        .count  (st_count),
        .full   (st_full),
        .empty  (st_empty)
    );

    assign leaf = (st_top <= N_W'(BASE_MAX));

    // Far term goes under the near term so the near branch is walked first
    always_comb begin
        near_term = st_top - N_W'(1);
        far_term  = st_top - N_W'(2);
        unique case (mode_q)
            TWOTHREE_FIB: begin
                near_term = st_top - N_W'(1);
                far_term  = st_top - N_W'(2);
            end
            TWOTHREE_PAD: begin
                near_term = st_top - N_W'(2);
                far_term  = (st_top > N_W'(2)) ? st_top - N_W'(3) : '0;
            end
        endcase
    end

    assign st_new = (state_q == LOAD) ? n_q : near_term;

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        mode_d  = mode_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        sat_d   = sat_q;
        st_clr  = 1'b0;
        st_push = 1'b0;
        st_pop  = 1'b0;
        st_repl = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    n_d     = n;
                    mode_d  = twothree;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                st_clr  = 1'b1;
                st_push = 1'b1;
                acc_d   = '0;
                ovf_d   = 1'b0;
                sat_d   = 1'b0;
                state_d = EVAL;
            end
            EVAL: begin
                if (st_empty) begin
                    state_d = FIN;
                end else if (leaf) begin
                    st_pop = 1'b1;
                    if (&acc_q) sat_d = 1'b1;
                    else        acc_d = acc_q + R_W'(1);
                    if (st_count == CNT_W'(1)) state_d = FIN;
                end else if (st_full) begin
                    ovf_d   = 1'b1;
                    state_d = FIN;
                end else begin
                    st_repl = 1'b1;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            n_q     <= '0;
            mode_q  <= TWOTHREE_FIB;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            mode_q  <= mode_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            sat_q   <= sat_d;
        end
    end

    assign busy      = (state_q == LOAD) || (state_q == EVAL);
    assign done      = (state_q == FIN);
    assign result    = acc_q;
    assign overflow  = ovf_q;
    assign saturated = sat_q;

endmodule

// File: tb/tb_rec_eval_engine.sv
// Self-checking bench for rec_eval_engine: three instances (default,
// shallow LIFO, narrow accumulator) scored against an iterative model.
module tb_rec_eval_engine;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       twothree = 1'b0;
    logic [3:0] n = '0;
    logic       start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;

    logic       busy0, done0, ovf0, sat0;
    logic [7:0] res0;
    logic       busy1, done1, ovf1, sat1;
    logic [7:0] res1;
    logic       busy2, done2, ovf2, sat2;
    logic [3:0] res2;

    always #5 clk = ~clk;

    rec_eval_engine #(.N_W(4), .R_W(8), .DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start0), .twothree(twothree), .n(n),
        .busy(busy0), .done(done0), .result(res0), .overflow(ovf0), .saturated(sat0)
    );

    rec_eval_engine #(.N_W(4), .R_W(8), .DEPTH(2)) dut_d2 (
        .clk(clk), .rst_n(rst_n), .start(start1), .twothree(twothree), .n(n),
        .busy(busy1), .done(done1), .result(res1), .overflow(ovf1), .saturated(sat1)
    );

    rec_eval_engine #(.N_W(4), .R_W(4), .DEPTH(8)) dut_r4 (
        .clk(clk), .rst_n(rst_n), .start(start2), .twothree(twothree), .n(n),
        .busy(busy2), .done(done2), .result(res2), .overflow(ovf2), .saturated(sat2)
    );

    typedef struct {
        logic [7:0] res;
        logic       ovf;
        logic       sat;
        int         lat;
        int         bsy;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;

    function automatic int model_f(input logic tt, input int k);
        int t[16];
        for (int i = 0; i < 16; i++) begin
            if (i <= 1)  t[i] = 1;
            else if (tt) t[i] = t[i-1] + t[i-2];
            else         t[i] = t[i-2] + ((i >= 3) ? t[i-3] : t[0]);
        end
        return t[k];
    endfunction

    task automatic push_model(input logic tt, input int nn, input int rw);
        exp_t e;
        int   f    = model_f(tt, nn);
        int   maxv = (1 << rw) - 1;
        e.res = 8'((f > maxv) ? maxv : f);
        e.ovf = 1'b0;
        e.sat = (f > maxv);
        e.lat = 2 * f + 1;
        e.bsy = 2 * f;
        sb.push_back(e);
    endtask

    task automatic set_start(input int inst, input logic v);
        start0 = (inst == 0) && v;
        start1 = (inst == 1) && v;
        start2 = (inst == 2) && v;
    endtask

    task automatic get_outs(input int inst, output logic b, output logic d,
                            output logic [7:0] r, output logic o, output logic s);
        case (inst)
            0:       begin b = busy0; d = done0; r = res0;          o = ovf0; s = sat0; end
            1:       begin b = busy1; d = done1; r = res1;          o = ovf1; s = sat1; end
            default: begin b = busy2; d = done2; r = {4'b0, res2}; o = ovf2; s = sat2; end
        endcase
    endtask

    // Drive one start, then score the completed run against the queue head
    task automatic run(input int inst, input logic tt, input logic [3:0] nn,
                       input int inject_at, input string name);
        exp_t       e;
        int         cyc, bcnt;
        logic       got, b, d, o, s;
        logic [7:0] r;
        @(negedge clk);
        twothree = tt;
        n        = nn;
        set_start(inst, 1'b1);
        cyc = 0; bcnt = 0; got = 1'b0;
        b = 1'b0; d = 1'b0; r = '0; o = 1'b0; s = 1'b0;
        while (!got && cyc < 200) begin
            @(negedge clk);
            cyc++;
            set_start(inst, cyc == inject_at);
            if (cyc == 1 || cyc == inject_at) begin
                n        = ~nn;
                twothree = ~tt;
            end
            get_outs(inst, b, d, r, o, s);
            if (d) got = 1'b1;
            else if (b) bcnt++;
        end
        set_start(inst, 1'b0);
        if (sb.size() == 0) begin
            checks++; fails++;
            $display("FAIL %s scoreboard: empty queue, required one entry", name);
            return;
        end
        e = sb.pop_front();
        checks++;
        if (got !== 1'b1) begin
            fails++;
            $display("FAIL %s done_timeout: no done within %0d cycles", name, cyc);
        end else begin
            checks++;
            if (cyc !== e.lat) begin fails++; $display("FAIL %s latency: got %0d expected %0d", name, cyc, e.lat); end
            checks++;
            if (bcnt !== e.bsy) begin fails++; $display("FAIL %s busy_cycles: got %0d expected %0d", name, bcnt, e.bsy); end
            checks++;
            if (b !== 1'b0) begin fails++; $display("FAIL %s busy_at_done: got %b expected 0", name, b); end
            checks++;
            if (r !== e.res) begin fails++; $display("FAIL %s result: got %0d expected %0d", name, r, e.res); end
            checks++;
            if (o !== e.ovf) begin fails++; $display("FAIL %s overflow: got %b expected %b", name, o, e.ovf); end
            checks++;
            if (s !== e.sat) begin fails++; $display("FAIL %s saturated: got %b expected %b", name, s, e.sat); end
            @(negedge clk);
            get_outs(inst, b, d, r, o, s);
            checks++;
            if ({d, b} !== 2'b00) begin fails++; $display("FAIL %s after_done done/busy: got %b%b expected 00", name, d, b); end
            checks++;
            if (r !== e.res) begin fails++; $display("FAIL %s result_hold: got %0d expected %0d", name, r, e.res); end
        end
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({busy0, done0, res0, ovf0, sat0} !== 12'h0) begin
            fails++;
            $display("FAIL reset inst0: got %b expected all zero", {busy0, done0, res0, ovf0, sat0});
        end
        checks++;
        if ({busy1, done1, res1, ovf1, sat1, busy2, done2, res2, ovf2, sat2} !== 20'h0) begin
            fails++;
            $display("FAIL reset inst1/2: got %b expected all zero",
                     {busy1, done1, res1, ovf1, sat1, busy2, done2, res2, ovf2, sat2});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fib;
        push_model(1'b1, 5, 8);  run(0, 1'b1, 4'd5, -1, "fib_n5");
        push_model(1'b1, 7, 8);  run(0, 1'b1, 4'd7, -1, "fib_n7");
    endtask

    task automatic test_pad;
        push_model(1'b0, 7, 8);  run(0, 1'b0, 4'd7, -1, "pad_n7");
        push_model(1'b0, 2, 8);  run(0, 1'b0, 4'd2, -1, "pad_n2_clamp");
        push_model(1'b0, 3, 8);  run(0, 1'b0, 4'd3, -1, "pad_n3");
    endtask

    task automatic test_base_cases;
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 2; k++) begin
                push_model(m[0], k, 8);
                run(0, m[0], 4'(k), -1, $sformatf("base_m%0d_n%0d", m, k));
            end
        end
    endtask

    task automatic test_overflow;
        exp_t e;
        e.res = 8'd0; e.ovf = 1'b1; e.sat = 1'b0; e.lat = 4; e.bsy = 3;
        sb.push_back(e);
        run(1, 1'b0, 4'd7, -1, "ovf_depth2");
        // a following run on the same instance must start from an empty stack
        push_model(1'b1, 1, 8);
        run(1, 1'b1, 4'd1, -1, "after_ovf_n1");
    endtask

    task automatic test_saturation;
        push_model(1'b1, 7, 4);  run(2, 1'b1, 4'd7, -1, "sat_r4_fib_n7");
        push_model(1'b0, 5, 4);  run(2, 1'b0, 4'd5, -1, "nosat_r4_pad_n5");
    endtask

    task automatic test_start_while_busy;
        push_model(1'b1, 5, 8);  run(0, 1'b1, 4'd5, 3, "start_busy_ignored");
    endtask

    task automatic test_back_to_back;
        push_model(1'b0, 6, 8);  run(0, 1'b0, 4'd6, -1, "b2b_first");
        push_model(1'b1, 4, 8);  run(0, 1'b1, 4'd4, -1, "b2b_second");
    endtask

    task automatic test_reset_mid_run;
        logic seen_done;
        @(negedge clk);
        twothree = 1'b1; n = 4'd5; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (busy0 !== 1'b1) begin fails++; $display("FAIL midrst busy_before: got %b expected 1", busy0); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy0, done0, res0, ovf0, sat0} !== 12'h0) begin
            fails++;
            $display("FAIL midrst outputs: got %b expected all zero", {busy0, done0, res0, ovf0, sat0});
        end
        seen_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done0) seen_done = 1'b1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done0 || busy0) seen_done = 1'b1;
        end
        checks++;
        if (seen_done !== 1'b0) begin fails++; $display("FAIL midrst no_done: got activity expected none"); end
        push_model(1'b1, 3, 8);
        run(0, 1'b1, 4'd3, -1, "after_midrst");
    endtask

    initial begin
        test_reset;
        test_fib;
        test_pad;
        test_base_cases;
        test_overflow;
        test_saturation;
        test_start_while_busy;
        test_back_to_back;
        test_reset_mid_run;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
